// File: rtl/img_processing_pkg.sv
// Shared image-pipeline types: border modes, kernel limits, pixel type.
// Used by axis_window_gen and its line memories.
package img_processing_pkg;

  typedef enum logic {
    BORDER_ZERO      = 1'b0,
    BORDER_REPLICATE = 1'b1
  } border_mode_t;

  localparam int MAX_KERNEL_SIZE = 7;
  localparam int PIXEL_W_DEF     = 8;
  localparam int CHANNELS_DEF    = 1;

  typedef logic [PIXEL_W_DEF*CHANNELS_DEF-1:0] pixel_t;

  function automatic int clamp_lo(input int v, input int lo);
    return (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/window_line_mem.sv
// One video line of pixel storage: combinational read, synchronous write.
// Read and write share one address so the old word is read before overwrite.
module window_line_mem
  import img_processing_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/axis_window_gen.sv
// Streaming KxK sliding-window generator over AXI-Stream video.
// Define AXIS_WINDOW_REPLICATE_EN to build replicate-edge border mode.
module axis_window_gen
  import img_processing_pkg::*;
#(
  parameter int IMG_W       = 640,
  parameter int KERNEL_SIZE = 3,
  parameter int PIXEL_W     = 8,
  parameter int CHANNELS    = 1
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic border_mode,
  input  logic [PIXEL_W*CHANNELS-1:0] s_axis_tdata,
  input  logic s_axis_tvalid,
  output logic s_axis_tready,
  input  logic s_axis_tuser,
  input  logic s_axis_tlast,
  output logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_W*CHANNELS-1:0] m_axis_tdata,
  output logic m_axis_tvalid,
  input  logic m_axis_tready,
  output logic [1:0] m_axis_tuser,
  output logic m_axis_tlast,
  output logic frame_err
);

  localparam int K  = KERNEL_SIZE;
  localparam int PW = PIXEL_W * CHANNELS;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(K);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic acc, sof, last_col, err_d, rep;
  logic [1:0] tuser_d;
  logic [K*K*PW-1:0] tdata_d;
  logic [PW-1:0] wd [K-1];
  logic [PW-1:0] rd [K-1];
  logic [PW-1:0] col_v [K];
  logic [PW-1:0] raw_q [K][K];
  logic [PW-1:0] raw_d [K][K];
  int rlim, clim;

  assign s_axis_tready = m_axis_tready | ~m_axis_tvalid;
  assign acc = s_axis_tvalid & s_axis_tready;
  assign sof = s_axis_tuser;
  assign cur_col = sof ? '0 : col_q;
  assign cur_row = sof ? '0 : row_q;
  assign last_col = (cur_col == CW'(IMG_W - 1));
  assign err_d = (s_axis_tlast & ~last_col)
               | (last_col & ~s_axis_tlast)
               | (sof & (col_q != '0));
  assign tuser_d = {(cur_row == RW'(K - 1))
                    & (cur_col >= CW'(K - 1)), sof};

`ifdef AXIS_WINDOW_REPLICATE_EN
  border_mode_t mode_q;

  assign rep = sof ? border_mode : (mode_q == BORDER_REPLICATE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) mode_q <= BORDER_ZERO;
    else if (acc & sof) mode_q <= border_mode_t'(border_mode);
  end
`else
  logic unused_border;

  assign unused_border = border_mode;
  assign rep = 1'b0;
`endif

  // Line 0 holds the previous row; each line ages into the next one.
  for (genvar i = 0; i < K - 1; i++) begin : g_line
    if (i == 0) begin : g_first
      assign wd[i] = s_axis_tdata;
    end else begin : g_next
      assign wd[i] = rd[i-1];
    end
    window_line_mem #(
      .DEPTH(IMG_W),
      .WIDTH(PW)
    ) u_mem (
      .clk_i  (aclk),
      .we_i   (acc),
      .addr_i (cur_col),
      .wdata_i(wd[i]),
      .rdata_o(rd[i])
    );
  end

  always_comb begin
    col_v[K-1] = s_axis_tdata;
    for (int i = 0; i < K - 1; i++) col_v[K-2-i] = rd[i];
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) raw_d[r][c] = raw_q[r][c+1];
      raw_d[r][K-1] = col_v[r];
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (acc) begin
      if (s_axis_tlast | last_col) begin
        col_d = '0;
        row_d = (cur_row == RW'(K - 1)) ? cur_row : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  // Out-of-frame taps are zeroed or pulled from the nearest valid tap.
  always_comb begin
    tdata_d = '0;
    rlim = K - 1 - int'(cur_row);
    clim = K - 1 - int'(cur_col);
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (r >= rlim && c >= clim) begin
          tdata_d[(r*K+c)*PW +: PW] = raw_d[r][c];
        end else if (rep) begin
          for (int a = 0; a < K; a++) begin
            for (int b = 0; b < K; b++) begin
              if (a == clamp_lo(r, rlim) && b == clamp_lo(c, clim))
                tdata_d[(r*K+c)*PW +: PW] = raw_d[a][b];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      col_q         <= '0;
      row_q         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      frame_err     <= 1'b0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) raw_q[r][c] <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      frame_err <= acc & err_d;
      if (acc) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= tdata_d;
        m_axis_tuser  <= tuser_d;
        m_axis_tlast  <= s_axis_tlast;
        raw_q         <= raw_d;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_window_gen.sv
// Bench for axis_window_gen: directed tables plus randomized frames
// checked against a frame-image reference model.
module tb_axis_window_gen;

  localparam int W  = 4;
  localparam int K  = 3;
  localparam int DW = K * K * 8;
`ifdef AXIS_WINDOW_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       u;
    logic       l;
  } beat_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    u;
    logic          l;
  } obeat_t;

  typedef struct {
    string         name;
    int            idx;
    logic [DW-1:0] d;
    logic [1:0]    u;
    logic          l;
  } vec_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          border_mode;
  logic [7:0]    s_tdata;
  logic          s_tvalid, s_tready, s_tuser, s_tlast;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast, frame_err;
  logic [1:0]    m_tuser;

  int checks = 0;
  int passed = 0;
  int err_pulses;
  logic exp_err = 1'b0;
  logic [DW-1:0] held;

  beat_t  stim[$];
  obeat_t got[$];
  obeat_t run1[$];
  obeat_t exp_q[$];
  vec_t   tbl[7];

  int m_row = 0;
  int m_col = 0;
  bit m_mode = 1'b0;
  logic [7:0] img [16][W];

  always #5 aclk = ~aclk;

  axis_window_gen #(
    .IMG_W(W), .KERNEL_SIZE(K), .PIXEL_W(8), .CHANNELS(1)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .border_mode(border_mode),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
    .frame_err(frame_err)
  );

  task automatic chk(input string n, input logic [DW-1:0] a,
                     input logic [DW-1:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endtask

  function automatic logic [DW-1:0] pk(
    input int a0, input int a1, input int a2,
    input int a3, input int a4, input int a5,
    input int a6, input int a7, input int a8);
    return {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0],
            a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  task automatic push(input int d, input bit u, input bit l);
    beat_t b;
    b.d = d[7:0];
    b.u = u;
    b.l = l;
    stim.push_back(b);
  endtask

  task automatic add_frame(input int rows, input bit rnd, input int extra);
    int r, c;
    for (int i = 0; i < rows * W + extra; i++) begin
      r = i / W;
      c = i % W;
      push(rnd ? int'($urandom_range(255)) : r * 16 + c, i == 0, c == W - 1);
    end
  endtask

  // Reference: keep the frame as a 2-D image and cut windows from it.
  task automatic model_accept(input beat_t b, input logic bm,
                              output logic err);
    int r, c, sr, sc;
    logic [7:0] px;
    obeat_t o;
    if (b.u) begin
      r = 0;
      c = 0;
      m_mode = bm & REP;
    end else begin
      r = m_row;
      c = m_col;
    end
    err = (b.l && c != W - 1) || (c == W - 1 && !b.l) || (b.u && m_col != 0);
    img[r][c] = b.d;
    o.d = '0;
    for (int tr = 0; tr < K; tr++) begin
      for (int tc = 0; tc < K; tc++) begin
        sr = r - (K - 1 - tr);
        sc = c - (K - 1 - tc);
        if (sr >= 0 && sc >= 0) px = img[sr][sc];
        else if (m_mode) px = img[sr < 0 ? 0 : sr][sc < 0 ? 0 : sc];
        else px = 8'h00;
        o.d[(tr*K+tc)*8 +: 8] = px;
      end
    end
    o.u = {(r >= K - 1 && c >= K - 1), b.u};
    o.l = b.l;
    exp_q.push_back(o);
    if (b.l || c == W - 1) begin
      m_col = 0;
      m_row = r + 1;
    end else begin
      m_col = c + 1;
      m_row = r;
    end
  endtask

  task automatic run(input int vpct, input int rpct, input bit cmp,
                     input int stall_at);
    int cyc;
    bit done, hs_o, hs_i;
    logic e;
    beat_t b;
    obeat_t o, x;
    cyc = 0;
    done = 0;
    err_pulses = 0;
    got.delete();
    exp_q.delete();
    while (!done) begin
      @(negedge aclk);
      cyc++;
      chk("frame_err", frame_err, exp_err);
      if (frame_err) err_pulses++;
      if (stall_at >= 0 && !m_tready) begin
        chk("stall_s_tready", s_tready, 0);
        chk("stall_tvalid", m_tvalid, 1);
        chk("stall_hold", m_tdata, held);
      end
      if (stim.size() > 0) begin
        s_tvalid = ($urandom_range(99) < vpct);
        s_tdata  = stim[0].d;
        s_tuser  = stim[0].u;
        s_tlast  = stim[0].l;
      end else begin
        s_tvalid = 1'b0;
      end
      if (stall_at >= 0) begin
        m_tready = !(cyc >= stall_at && cyc < stall_at + 5);
        if (cyc == stall_at) held = m_tdata;
      end else begin
        m_tready = ($urandom_range(99) < rpct);
      end
      #1;
      hs_o = m_tvalid && m_tready;
      hs_i = s_tvalid && s_tready;
      e = 1'b0;
      if (hs_o) begin
        o.d = m_tdata;
        o.u = m_tuser;
        o.l = m_tlast;
        got.push_back(o);
        if (exp_q.size() == 0) begin
          if (cmp) begin
            checks++;
            $display("FAIL extra_output: got %0h want none", o.d);
          end
        end else begin
          x = exp_q.pop_front();
          if (cmp) begin
            chk("win_data", o.d, x.d);
            chk("win_tuser", o.u, x.u);
            chk("win_tlast", o.l, x.l);
          end
        end
      end
      if (hs_i) begin
        b = stim.pop_front();
        model_accept(b, border_mode, e);
      end
      exp_err = e;
      if (stim.size() == 0 && !m_tvalid && !hs_i) begin
        done = 1;
      end else if (cyc > 3000) begin
        checks++;
        $display("FAIL timeout: got %0d cycles want <= 3000", cyc);
        stim.delete();
        done = 1;
      end
    end
  endtask

  initial begin
    tbl[0] = '{"px00", 0,  pk(0,0,0, 0,0,0, 0,0,0), 2'b01, 1'b0};
    tbl[1] = '{"px03", 3,  pk(0,0,0, 0,0,0, 'h01,'h02,'h03), 2'b00, 1'b1};
    tbl[2] = '{"px11", 5,  pk(0,0,0, 0,0,'h01, 0,'h10,'h11), 2'b00, 1'b0};
    tbl[3] = '{"px12", 6,  pk(0,0,0, 0,'h01,'h02, 'h10,'h11,'h12), 2'b00, 1'b0};
    tbl[4] = '{"px21", 9,  pk(0,0,'h01, 0,'h10,'h11, 0,'h20,'h21), 2'b00, 1'b0};
    tbl[5] = '{"px22", 10, pk(0,'h01,'h02, 'h10,'h11,'h12, 'h20,'h21,'h22),
               2'b10, 1'b0};
    tbl[6] = '{"px33", 15, pk('h11,'h12,'h13, 'h21,'h22,'h23, 'h31,'h32,'h33),
               2'b10, 1'b1};

    aresetn = 1'b0;
    border_mode = 1'b0;
    s_tdata = '0;
    s_tvalid = 1'b0;
    s_tuser = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_s_tready", s_tready, 1);
    aresetn = 1'b1;

    // Zero mode, continuous flow.
    add_frame(4, 0, 0);
    run(100, 100, 1, -1);
    chk("zero_count", got.size(), 16);
    if (got.size() == 16) begin
      foreach (tbl[i]) begin
        chk({tbl[i].name, "_data"}, got[tbl[i].idx].d, tbl[i].d);
        chk({tbl[i].name, "_tuser"}, got[tbl[i].idx].u, tbl[i].u);
        chk({tbl[i].name, "_tlast"}, got[tbl[i].idx].l, tbl[i].l);
      end
    end
    run1 = got;

    // Downstream stall mid-line.
    add_frame(4, 0, 0);
    run(100, 100, 1, 6);
    chk("stall_count", got.size(), 16);

    // Replicate border request.
    border_mode = 1'b1;
    add_frame(4, 0, 0);
    run(100, 100, 1, -1);
    if (got.size() > 1)
      chk("rep_px01", got[1].d, REP ? pk(0,0,1, 0,0,1, 0,0,1)
                                    : pk(0,0,0, 0,0,0, 0,0,1));
    else chk("rep_count", got.size(), 16);
    border_mode = 1'b0;

    // Short line: tlast at col 2.
    for (int c = 0; c < W; c++) push(c, c == 0, c == W - 1);
    for (int c = 0; c < 3; c++) push('h10 + c, 0, c == 2);
    for (int r = 2; r < 4; r++)
      for (int c = 0; c < W; c++) push(r * 16 + c, 0, c == W - 1);
    run(100, 100, 0, -1);
    chk("short_err_pulses", err_pulses, 1);
    if (got.size() > 7) begin
      chk("short_px20_data", got[7].d, pk(0,0,0, 0,0,'h10, 0,0,'h20));
      chk("short_px20_tuser", got[7].u, 2'b00);
    end else chk("short_count", got.size(), 15);

    // Reset in the middle of a frame.
    add_frame(2, 0, 1);
    run(100, 100, 1, -1);
    @(negedge aclk);
    s_tvalid = 1'b1;
    s_tdata = 8'h21;
    s_tuser = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    @(negedge aclk);
    s_tvalid = 1'b0;
    chk("pre_rst_tvalid", m_tvalid, 1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_tdata", m_tdata, 0);
    chk("mid_rst_tuser", m_tuser, 0);
    chk("mid_rst_tlast", m_tlast, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    m_row = 0;
    m_col = 0;
    m_mode = 1'b0;
    exp_err = 1'b0;
    add_frame(4, 0, 0);
    run(100, 100, 1, -1);
    chk("after_rst_count", got.size(), 16);
    if (got.size() == 16 && run1.size() == 16) begin
      for (int i = 0; i < 16; i++)
        chk("after_rst_repeat", {got[i].d, got[i].u, got[i].l},
            {run1[i].d, run1[i].u, run1[i].l});
    end

    // SOF arriving mid-line.
    push(1, 1, 0);
    push(2, 1, 0);
    run(100, 100, 1, -1);
    chk("sof_err_pulses", err_pulses, 1);

    // Random frames, random handshakes.
    for (int f = 0; f < 4; f++) begin
      int rows;
      rows = 3 + int'($urandom_range(3));
      border_mode = $urandom_range(1);
      add_frame(rows, 1, 0);
      run(70, 60, 1, -1);
      chk("rand_count", got.size(), rows * W);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axis_window_gen.md
# axis_window_gen

Streaming K×K sliding-window generator for the image pipeline. It accepts a raster-order AXI-Stream pixel stream (multi-channel), stores K-1 previous lines in internal line buffers, and emits one full K×K neighbourhood per accepted pixel. Out-of-frame taps are filled per a run-time border mode. It sits between the video input and the convolution/filter datapath, and replaces the fixed 3×3, 8-bit line-buffer arrangement with a generic one.

## Interface
- IMG_W, 640: pixels per line (≥ KERNEL_SIZE)
- KERNEL_SIZE, 3: window side; odd, 3..7
- PIXEL_W, 8: bits per channel
- CHANNELS, 1: channels per pixel, 1..4
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset; asynchronous, active-low
- border_mode  in  1  0 = zero-fill, 1 = replicate edge; sampled at SOF only
- s_axis_tdata  in  PIXEL_W*CHANNELS  pixel; channel n at [n*PIXEL_W +: PIXEL_W]
- s_axis_tvalid  in  1; s_axis_tready  out  1
- s_axis_tuser  in  1  start of frame (first pixel)
- s_axis_tlast  in  1  end of line
- m_axis_tdata  out  K*K*PIXEL_W*CHANNELS  window; tap (r,c) at [(r*K+c)*PIXEL_W*CHANNELS +: PIXEL_W*CHANNELS]; r=0 is the oldest row, c=0 is the oldest column
- m_axis_tvalid  out  1; m_axis_tready  in  1
- m_axis_tuser  out  2  [0] = SOF, [1] = window complete (all taps in-frame)
- m_axis_tlast  out  1  end of line, passed through
- frame_err  out  1  one-cycle pulse on line-length or SOF violation

## Operation
- Window is causal: bottom-right tap (K-1,K-1) is the just-accepted pixel at (row, col).
- Accept means s_axis_tvalid & s_axis_tready.
- On accept:
  - read K-1 line buffers at address col
  - shift line i into line i+1 at col; write the pixel into line 0
  - shift the new K-tall column into the K×K register array
- Counters col (0..IMG_W-1) and row (saturating at K-1) track position.
- SOF resets row=0, col=0 for that pixel and latches border_mode.
- tlast: next pixel is col 0, row+1.
- Tap (r,c) is out-of-frame when r < K-1-row or c < K-1-col.
  - Zero mode: out-of-frame taps read 0.
  - Replicate mode: row index clamps to the oldest valid row; column index clamps to col 0.
- m_axis_tuser[1] = (row ≥ K-1) & (col ≥ K-1).
- frame_err pulses in three cases:
  - tlast with col ≠ IMG_W-1
  - col = IMG_W-1 without tlast (the next pixel wraps to col 0, row+1)
  - SOF with col ≠ 0
- Line buffer contents are never cleared; masking makes stale data invisible.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, frame_err=0, counters 0, latched mode 0.
- Latency: 1 cycle, accept → m_axis_tvalid.
- Single output register; s_axis_tready = m_axis_tready | ~m_axis_tvalid.
- While m_axis_tvalid & ~m_axis_tready, m_axis_* stays stable and nothing is accepted.
- Throughput: one pixel per cycle when the downstream is ready.
- Reset mid-frame discards the partial frame. Stream before the next SOF is treated as row 0 continuation (taps masked).
- frame_err is asserted in the cycle after the offending accept.

## Configuration
- AXIS_WINDOW_REPLICATE_EN defined: replicate border mode is built as described.
- Not defined: replicate logic is omitted, border_mode is ignored, and zero-fill is always used.

## Structure
- img_processing_pkg gains:
  - border_mode_t (BORDER_ZERO, BORDER_REPLICATE)
  - MAX_KERNEL_SIZE = 7
  - a parametric pixel typedef
- Sub-module window_line_mem: one IMG_W-deep, PIXEL_W*CHANNELS-wide memory with combinational read and synchronous write. K-1 instances.

## Test plan
All cases use K=3, IMG_W=4, CHANNELS=1, pixel = row*16+col, unless stated.

- 4×4 frame, zero mode, pixel (1,1) → window {00,00,00, 00,00,01, 00,10,11}, tuser=2'b00.
- Same frame, pixel (2,2) → {00,01,02, 10,11,12, 20,21,22}, tuser[1]=1.
- Replicate mode, pixel (0,1) → every row {00,00,01}. With macro undefined → {00,00,00, 00,00,00, 00,00,01}.
- m_axis_tready low for 5 cycles mid-line:
  - m_axis_tdata constant
  - s_axis_tready low after one held output
  - all 16 windows delivered, none lost or repeated
- tlast at col 2 → frame_err pulse for 1 cycle; next pixel is treated as (row+1, 0).
- aresetn low at pixel (2,1) → all outputs 0 during reset; the following SOF frame reproduces the windows of the first scenario exactly.
